puf_response_collector: RTL and testbench

Sequencer and response capture stage that drives one `puf_parallel_subblock`. It is the block that feeds the subblock its challenge, ring-oscillator enables and reset. It also consumes the subblock's `out`/`done`. One `start` pulse produces a `RESP_BITS`-wide response word: one race per bit, with challenge `base_challenge + i`. The word is delivered to the downstream key/UART logic with a valid flag and a sticky timeout error.

---
 rtl/puf_response_collector.sv | 188 ++++++++++++++++++
 tb/tb_puf_response_collector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_collector.sv
// Sequences one puf_parallel_subblock through RESP_BITS races and assembles the response word.
// Each race gets base_challenge + idx; a race that never reports done is forced to 0 and flagged.
module puf_response_collector #(
  parameter int RESP_BITS    = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int TIMEOUT      = 2000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           base_challenge,
  input  logic                 puf_done,
  input  logic                 puf_out,
  output logic [31:0]          puf_enable,
  output logic [7:0]           puf_challenge,
  output logic                 puf_reset,
  output logic                 busy,
  output logic [RESP_BITS-1:0] response,
  output logic                 response_valid,
  output logic                 timeout_err
);

  // state     | meaning
  // S_IDLE    | waiting for start, subblock held in reset
  // S_CLEAR   | subblock held in reset for CLEAR_CYCLES before a race
  // S_RUN     | oscillators enabled, waiting for done or timeout
  // S_CAPTURE | write the race result into response[idx]
  // S_DONE    | response word valid and held until the next start

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int CLR_W = $clog2(CLEAR_CYCLES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           base_q, base_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_q, tmo_d;
  logic [RESP_BITS-1:0] response_q, response_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 response_valid_q, response_valid_d;
  logic                 busy_q, busy_d;
  logic                 puf_reset_q, puf_reset_d;
  logic [31:0]          puf_enable_q, puf_enable_d;
  logic [7:0]           puf_challenge_q, puf_challenge_d;
  logic                 done_s1_q, done_s1_d, done_s2_q, done_s2_d;
  logic                 out_s1_q, out_s1_d, out_s2_q, out_s2_d;

  // Synchronizers are flushed during CLEAR so a stale done from the previous race cannot leak in.
  always_comb begin
    done_s1_d = puf_done;
    done_s2_d = done_s1_q;
    out_s1_d  = puf_out;
    out_s2_d  = out_s1_q;
    if (state_q == S_CLEAR) begin
      done_s1_d = 1'b0;
      done_s2_d = 1'b0;
      out_s1_d  = 1'b0;
      out_s2_d  = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    idx_d         = idx_q;
    clr_cnt_d     = clr_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    tmo_d         = tmo_q;
    response_d    = response_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d        = base_challenge;
          idx_d         = '0;
          response_d    = '0;
          timeout_err_d = 1'b0;
          clr_cnt_d     = CLR_LOAD;
          state_d       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == '0) begin
          tmo_cnt_d = '0;
          state_d   = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q - CLR_W'(1);
        end
      end
      S_RUN: begin
        if (done_s2_q) begin
          tmo_d   = 1'b0;
          state_d = S_CAPTURE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_CAPTURE: begin
        response_d[idx_q] = tmo_q ? 1'b0 : out_s2_q;
        if (tmo_q) timeout_err_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          clr_cnt_d = CLR_LOAD;
          state_d   = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    puf_reset_d      = (state_d != S_RUN);
    puf_enable_d     = (state_d == S_RUN) ? 32'hFFFF_FFFF : 32'h0;
    busy_d           = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_CAPTURE);
    response_valid_d = (state_d == S_DONE);
    puf_challenge_d  = base_d + 8'(idx_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      base_q           <= '0;
      idx_q            <= '0;
      clr_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      tmo_q            <= 1'b0;
      response_q       <= '0;
      timeout_err_q    <= 1'b0;
      response_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      puf_reset_q      <= 1'b1;
      puf_enable_q     <= '0;
      puf_challenge_q  <= '0;
      done_s1_q        <= 1'b0;
      done_s2_q        <= 1'b0;
      out_s1_q         <= 1'b0;
      out_s2_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      idx_q            <= idx_d;
      clr_cnt_q        <= clr_cnt_d;
      tmo_cnt_q        <= tmo_cnt_d;
      tmo_q            <= tmo_d;
      response_q       <= response_d;
      timeout_err_q    <= timeout_err_d;
      response_valid_q <= response_valid_d;
      busy_q           <= busy_d;
      puf_reset_q      <= puf_reset_d;
      puf_enable_q     <= puf_enable_d;
      puf_challenge_q  <= puf_challenge_d;
      done_s1_q        <= done_s1_d;
      done_s2_q        <= done_s2_d;
      out_s1_q         <= out_s1_d;
      out_s2_q         <= out_s2_d;
    end
  end

  assign puf_enable     = puf_enable_q;
  assign puf_challenge  = puf_challenge_q;
  assign puf_reset      = puf_reset_q;
  assign busy           = busy_q;
  assign response       = response_q;
  assign response_valid = response_valid_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Randomized bench for puf_response_collector: a behavioural subblock model answers each race,
// and scoreboard queues of expected races and words are checked by independent monitors.
module tb_puf_response_collector;

  localparam int RB = 8;
  localparam int CC = 4;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    base_challenge;
  logic          puf_done = 1'b0;
  logic          puf_out  = 1'b0;
  logic [31:0]   puf_enable;
  logic [7:0]    puf_challenge;
  logic          puf_reset;
  logic          busy;
  logic [RB-1:0] response;
  logic          response_valid;
  logic          timeout_err;

  puf_response_collector #(.RESP_BITS(RB), .CLEAR_CYCLES(CC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .base_challenge(base_challenge),
    .puf_done(puf_done), .puf_out(puf_out), .puf_enable(puf_enable),
    .puf_challenge(puf_challenge), .puf_reset(puf_reset), .busy(busy),
    .response(response), .response_valid(response_valid), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] ch; int len; } race_t;
  typedef struct { logic [RB-1:0] resp; logic err; } word_t;

  race_t      race_q[$];
  word_t      word_q[$];
  int         cur_delay[RB];
  logic       cur_out[RB];
  logic [7:0] cur_base = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         aborting = 1'b0;
  int         en_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Subblock model: done rises cur_delay cycles after its reset is released, carrying cur_out.
  int         sb_cnt = 0;
  logic [7:0] sb_diff;
  always @(negedge clock) begin
    if (puf_reset) begin
      sb_cnt   = 0;
      puf_done = 1'b0;
      puf_out  = 1'b0;
    end else begin
      sb_cnt++;
      sb_diff = puf_challenge - cur_base;
      if (int'(sb_diff) < RB && sb_cnt >= cur_delay[int'(sb_diff)]) begin
        puf_done = 1'b1;
        puf_out  = cur_out[int'(sb_diff)];
      end
    end
  end

  // Race monitor: one record per contiguous stretch of puf_reset low.
  bit         in_run = 1'b0;
  int         run_len = 0;
  logic [7:0] run_ch;
  logic       run_en_ok;
  race_t      rx;
  always @(negedge clock) begin
    if (aborting) begin
      in_run = 1'b0;
    end else if (!puf_reset) begin
      if (!in_run) begin
        in_run    = 1'b1;
        run_len   = 0;
        run_ch    = puf_challenge;
        run_en_ok = 1'b1;
      end
      run_len++;
      if (puf_enable !== 32'hFFFF_FFFF || puf_challenge !== run_ch) run_en_ok = 1'b0;
    end else begin
      if (puf_enable !== 32'h0) en_bad++;
      if (in_run) begin
        in_run = 1'b0;
        if (race_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL race_unexpected: got challenge %0h expected no race", run_ch);
        end else begin
          rx = race_q.pop_front();
          check("race_challenge", run_ch, rx.ch);
          check("race_run_cycles", run_len, rx.len);
          check("race_enable_in_run", run_en_ok, 1'b1);
        end
      end
    end
  end

  // Word monitor: fires on each rise of response_valid.
  logic  prev_valid = 1'b0;
  logic  prev_busy = 1'b0;
  word_t wx;
  always @(negedge clock) begin
    if (!aborting && response_valid && !prev_valid) begin
      if (word_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL word_unexpected: got response %0h expected no word", response);
      end else begin
        wx = word_q.pop_front();
        check("word_response", response, wx.resp);
        check("word_timeout_err", timeout_err, wx.err);
        check("word_busy_falls_with_valid", {prev_busy, busy}, 2'b10);
        check("word_enable_outside_run", en_bad, 0);
        check("word_races_all_seen", race_q.size(), 0);
        en_bad = 0;
      end
    end
    prev_valid = response_valid;
    prev_busy  = busy;
  end

  task automatic check_reset_vals();
    check("rst_puf_enable", puf_enable, 32'h0);
    check("rst_puf_challenge", puf_challenge, 8'h00);
    check("rst_puf_reset", puf_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_response", response, '0);
    check("rst_response_valid", response_valid, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
  endtask

  // Reference: bit i is the subblock answer unless done comes too late, which forces 0 and flags.
  task automatic launch(input logic [7:0] b);
    word_t w;
    race_t r;
    @(negedge clock);
    cur_base = b;
    w.resp = '0;
    w.err  = 1'b0;
    for (int i = 0; i < RB; i++) begin
      r.ch = b + 8'(i);
      if (cur_delay[i] <= TO - 2) begin
        w.resp[i] = cur_out[i];
        r.len     = cur_delay[i] + 2;
      end else begin
        w.err = 1'b1;
        r.len = TO;
      end
      race_q.push_back(r);
    end
    word_q.push_back(w);
    start          = 1'b1;
    base_challenge = b;
    @(posedge clock);
    #1;
    start          = 1'b0;
    base_challenge = 8'($urandom);
    check("start_busy", busy, 1'b1);
    check("start_valid_cleared", response_valid, 1'b0);
    check("start_response_zeroed", response, '0);
    check("start_err_cleared", timeout_err, 1'b0);
    check("start_puf_reset", puf_reset, 1'b1);
    check("start_challenge", puf_challenge, b);
  endtask

  task automatic wait_word();
    int k = 0;
    while (!response_valid && k < 3000) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if (!response_valid) begin
      n_bad++;
      $display("FAIL wait_word: got no response_valid expected it within 3000 cycles");
    end
  endtask

  task automatic wait_reset_level(input logic lvl);
    int k = 0;
    while (puf_reset !== lvl && k < 300) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if (puf_reset !== lvl) begin
      n_bad++;
      $display("FAIL wait_puf_reset: got %0b expected %0b within 300 cycles", puf_reset, lvl);
    end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clock);
    start          = 1'b1;
    base_challenge = b;
    @(negedge clock);
    start          = 1'b0;
  endtask

  task automatic set_parity_outs(input logic [7:0] b, input int d);
    logic [7:0] ch;
    for (int i = 0; i < RB; i++) begin
      ch           = b + 8'(i);
      cur_delay[i] = d;
      cur_out[i]   = ch[0];
    end
  endtask

  task automatic set_random(input bit edges);
    int r;
    for (int i = 0; i < RB; i++) begin
      r = edges ? int'($urandom_range(0, 9)) : 9;
      case (r)
        0:       cur_delay[i] = TO - 2;
        1:       cur_delay[i] = TO - 1;
        2:       cur_delay[i] = 500;
        default: cur_delay[i] = int'($urandom_range(1, 60));
      endcase
      cur_out[i] = 1'($urandom);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test expected finish before 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    base_challenge = 8'h00;
    set_parity_outs(8'h00, 50);
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals();
    @(negedge clock);
    reset = 1'b0;

    // Parity answers from base 10 give AA.
    set_parity_outs(8'h10, 50);
    launch(8'h10);
    wait_word();

    // Challenge wrap from FE.
    set_random(1'b0);
    launch(8'hFE);
    wait_word();

    // Race 2 never answers.
    set_parity_outs(8'h40, 30);
    cur_delay[2] = 1000;
    launch(8'h40);
    wait_word();

    // Start in DONE clears the error; done exactly at the timeout limit, and one cycle too late.
    set_random(1'b0);
    cur_delay[0] = TO - 2; cur_out[0] = 1'b1;
    cur_delay[1] = TO - 1; cur_out[1] = 1'b1;
    cur_delay[3] = TO - 2; cur_out[3] = 1'b0;
    launch(8'($urandom));
    wait_word();

    // Starts during RUN and CLEAR are ignored.
    set_random(1'b0);
    for (int i = 0; i < RB; i++) cur_delay[i] = 50;
    launch(8'h33);
    for (int n = 0; n < 4; n++) begin
      wait_reset_level(1'b0);
      repeat ($urandom_range(0, 20)) @(negedge clock);
      pulse_start(8'hC0);
      wait_reset_level(1'b1);
      pulse_start(8'hC1);
    end
    wait_word();

    // Reset mid-RUN aborts everything.
    set_parity_outs(8'h77, 50);
    launch(8'h77);
    wait_reset_level(1'b0);
    repeat (10) @(negedge clock);
    aborting = 1'b1;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_vals();
    @(negedge clock);
    @(negedge clock);
    race_q.delete();
    word_q.delete();
    en_bad   = 0;
    aborting = 1'b0;

    set_random(1'b0);
    launch(8'h5A);
    wait_word();

    for (int n = 0; n < 5; n++) begin
      set_random(1'b1);
      launch(8'($urandom));
      wait_word();
    end

    repeat (5) @(negedge clock);
    check("end_words_pending", word_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
